// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the mm:ss countdown timer.
package countdown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_ALARM  = 3'd4
    } state_e;

    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam logic [3:0] SEC_TEN_MAX = 4'd5;

    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
        logic [3:0] res;
        if (val > max) begin
            res = max;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command, digit-setting and display signals of the countdown timer.
interface countdown_timer_if;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] in_min_ten;
    logic [3:0] in_min_unit;
    logic [3:0] in_sec_ten;
    logic [3:0] in_sec_unit;
    logic [3:0] out_min_ten;
    logic [3:0] out_min_unit;
    logic [3:0] out_sec_ten;
    logic [3:0] out_sec_unit;
    logic       running;
    logic       done;
    logic       alarm;

    modport master (
        output load, start, pause, in_min_ten, in_min_unit, in_sec_ten, in_sec_unit,
        input  out_min_ten, out_min_unit, out_sec_ten, out_sec_unit, running, done, alarm
    );

    modport slave (
        input  load, start, pause, in_min_ten, in_min_unit, in_sec_ten, in_sec_unit,
        output out_min_ten, out_min_unit, out_sec_ten, out_sec_unit, running, done, alarm
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; a zero digit that is borrowed from wraps to MAX.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       is_zero
);
    logic [3:0] digit_r;

    // Digit register: load beats decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_r <= 4'd0;
        end else if (load) begin
            digit_r <= load_val;
        end else if (dec_en && borrow_in) begin
            if (digit_r == 4'd0) begin
                digit_r <= MAX;
            end else begin
                digit_r <= digit_r - 4'd1;
            end
        end
    end

    assign digit   = digit_r;
    assign is_zero = (digit_r == 4'd0);
endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: captures BCD digits, counts down at one tick per second,
// and raises a one-cycle done pulse plus a timed alarm at 00:00.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int ALARM_TICKS = 5
) (
    input logic               clk,
    input logic               rst,
    countdown_timer_if.slave  bus
);
    localparam int PW = $clog2(TICK_CYCLES);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
    localparam logic [AW-1:0] ALARM_ONE  = AW'(1);
    localparam logic [AW-1:0] ALARM_ZERO = AW'(0);

    state_e        state_r, state_nx_s;
    logic [PW-1:0] presc_r, presc_nx_s;
    logic [AW-1:0] alarm_cnt_r;
    logic          running_r, done_r, alarm_r;
    logic [3:0]    cap_mt_s, cap_mu_s, cap_st_s, cap_su_s;
    logic [3:0]    mt_s, mu_s, st_s, su_s;
    logic          mt_z_s, mu_z_s, st_z_s, su_z_s;
    logic          cap_zero_s, load_cmd_s, start_cmd_s, pause_cmd_s;
    logic          tick_s, time_zero_s, last_sec_s, dec_s, expire_s;

    assign cap_mt_s = clamp_digit(bus.in_min_ten,  DIGIT_MAX);
    assign cap_mu_s = clamp_digit(bus.in_min_unit, DIGIT_MAX);
    assign cap_st_s = clamp_digit(bus.in_sec_ten,  SEC_TEN_MAX);
    assign cap_su_s = clamp_digit(bus.in_sec_unit, DIGIT_MAX);
    assign cap_zero_s = ({cap_mt_s, cap_mu_s, cap_st_s, cap_su_s} == 16'd0);

    // Highest-priority command wins; load and start have no effect while running.
    assign load_cmd_s  = bus.load && (state_r != ST_RUN);
    assign start_cmd_s = bus.start && !bus.load && (state_r != ST_RUN);
    assign pause_cmd_s = bus.pause && !bus.load && !bus.start;

    assign tick_s      = ((state_r == ST_RUN) || (state_r == ST_ALARM)) && (presc_r == PRESC_LAST);
    assign time_zero_s = mt_z_s && mu_z_s && st_z_s && su_z_s;
    assign last_sec_s  = mt_z_s && mu_z_s && st_z_s && (su_s == 4'd1);
    assign dec_s       = tick_s && (state_r == ST_RUN) && !time_zero_s;
    assign expire_s    = dec_s && last_sec_s;

    bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_unit (
        .clk(clk), .rst(rst), .load(load_cmd_s), .load_val(cap_su_s),
        .dec_en(dec_s), .borrow_in(1'b1), .digit(su_s), .is_zero(su_z_s)
    );
    bcd_digit_down #(.MAX(SEC_TEN_MAX)) u_sec_ten (
        .clk(clk), .rst(rst), .load(load_cmd_s), .load_val(cap_st_s),
        .dec_en(dec_s), .borrow_in(su_z_s), .digit(st_s), .is_zero(st_z_s)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_unit (
        .clk(clk), .rst(rst), .load(load_cmd_s), .load_val(cap_mu_s),
        .dec_en(dec_s), .borrow_in(su_z_s && st_z_s), .digit(mu_s), .is_zero(mu_z_s)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ten (
        .clk(clk), .rst(rst), .load(load_cmd_s), .load_val(cap_mt_s),
        .dec_en(dec_s), .borrow_in(su_z_s && st_z_s && mu_z_s), .digit(mt_s), .is_zero(mt_z_s)
    );

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_READY, ST_PAUSED: begin
                if (load_cmd_s) begin
                    state_nx_s = cap_zero_s ? ST_IDLE : ST_READY;
                end else if (start_cmd_s && (state_r != ST_IDLE)) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RUN: begin
                if (expire_s) begin
                    state_nx_s = ST_ALARM;
                end else if (pause_cmd_s) begin
                    state_nx_s = ST_PAUSED;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (load_cmd_s) begin
                    state_nx_s = cap_zero_s ? ST_IDLE : ST_READY;
                end else if (start_cmd_s || pause_cmd_s) begin
                    state_nx_s = ST_IDLE;
                end else if (tick_s && (alarm_cnt_r == ALARM_LAST)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ALARM;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Prescaler next value: a pause freezes the count, even on a tick cycle.
    always_comb begin
        presc_nx_s = presc_r;
        case (state_r)
            ST_READY: begin
                if (start_cmd_s) begin
                    presc_nx_s = PRESC_ZERO;
                end else begin
                    presc_nx_s = presc_r;
                end
            end
            ST_RUN, ST_ALARM: begin
                if ((state_r == ST_RUN) && pause_cmd_s && !expire_s) begin
                    presc_nx_s = presc_r;
                end else if (tick_s) begin
                    presc_nx_s = PRESC_ZERO;
                end else begin
                    presc_nx_s = presc_r + PRESC_ONE;
                end
            end
            default: presc_nx_s = presc_r;
        endcase
    end

    // State, prescaler, alarm tick count and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            presc_r     <= PRESC_ZERO;
            alarm_cnt_r <= ALARM_ZERO;
            running_r   <= 1'b0;
            done_r      <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            presc_r   <= presc_nx_s;
            running_r <= (state_nx_s == ST_RUN);
            alarm_r   <= (state_nx_s == ST_ALARM);
            done_r    <= expire_s;
            if (expire_s) begin
                alarm_cnt_r <= ALARM_ZERO;
            end else if ((state_r == ST_ALARM) && tick_s) begin
                alarm_cnt_r <= alarm_cnt_r + ALARM_ONE;
            end
        end
    end

    assign bus.out_min_ten  = mt_s;
    assign bus.out_min_unit = mu_s;
    assign bus.out_sec_ten  = st_s;
    assign bus.out_sec_unit = su_s;
    assign bus.running      = running_r;
    assign bus.done         = done_r;
    assign bus.alarm        = alarm_r;
endmodule
